// File: rtl/lane_runner_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_runner_pkg
// Brief    : Game-phase encoding and default geometry for the lane runner.
// Revision : 1.0
// ============================================================================
package lane_runner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int C_NUM_LANES = 6;
    localparam int C_XW        = 10;
    localparam int C_SCREEN_W  = 640;
    localparam int C_OBJ_W     = 20;
    localparam int C_PLAYER_X  = 320;
    localparam int C_PLAYER_HW = 30;
    localparam int C_SPEED_W   = 4;
    localparam int C_LIVES     = 3;
    localparam int C_SCORE_MAX = 10;
    localparam int C_HIT_TICKS = 8;

endpackage : lane_runner_pkg
`default_nettype wire

// File: rtl/lane_runner_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : lane_runner_engine_if
// Brief    : Control inputs and render/status outputs of the lane runner.
// Revision : 1.0
// ============================================================================
interface lane_runner_engine_if #(
    parameter int NUM_LANES = 6,
    parameter int XW        = 10,
    parameter int SPEED_W   = 4,
    parameter int LIVES     = 3,
    parameter int SCORE_MAX = 10
);
    localparam int ROW_W   = $clog2(NUM_LANES + 1);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int SCORE_W = $clog2(SCORE_MAX + 1);

    logic                         tick;
    logic                         start;
    logic                         btn_up;
    logic                         btn_down;
    logic [NUM_LANES*SPEED_W-1:0] lane_speed;
    logic [NUM_LANES-1:0]         lane_dir;
    logic [NUM_LANES*XW-1:0]      obs_x;
    logic [ROW_W-1:0]             player_row;
    logic [2:0]                   state;
    logic [LIVES_W-1:0]           lives;
    logic [SCORE_W-1:0]           score;
    logic                         hit;

    modport master (
        output tick, start, btn_up, btn_down, lane_speed, lane_dir,
        input  obs_x, player_row, state, lives, score, hit
    );

    modport slave (
        input  tick, start, btn_up, btn_down, lane_speed, lane_dir,
        output obs_x, player_row, state, lives, score, hit
    );

endinterface : lane_runner_engine_if
`default_nettype wire

// File: rtl/lane_runner_engine_obstacle.sv
`default_nettype none
// ============================================================================
// Module   : lane_obstacle
// Brief    : One scrolling obstacle X register with modulo-SCREEN_W wrap.
// Revision : 1.0
// ============================================================================
module lane_obstacle #(
    parameter int XW       = 10,
    parameter int SPEED_W  = 4,
    parameter int SCREEN_W = 640,
    parameter int INIT_X   = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_en,
    input  wire logic               i_load,
    input  wire logic [SPEED_W-1:0] i_speed,
    input  wire logic               i_dir,
    output logic      [XW-1:0]      o_x
);
    localparam logic [XW:0]   C_SCREEN = (XW+1)'(SCREEN_W);
    localparam logic [XW-1:0] C_INIT   = XW'(INIT_X);

    logic [XW-1:0] r_x;
    logic [XW:0]   w_x_ext;
    logic [XW:0]   w_spd;
    logic [XW:0]   w_sum;
    logic [XW:0]   w_right;
    logic [XW:0]   w_left;
    logic [XW-1:0] w_next;

    // One extra bit keeps x + s and x + SCREEN_W - s from overflowing.
    assign w_x_ext = {1'b0, r_x};
    assign w_spd   = (XW+1)'(i_speed);
    assign w_sum   = w_x_ext + w_spd;
    assign w_right = (w_sum >= C_SCREEN) ? (w_sum - C_SCREEN) : w_sum;
    assign w_left  = (w_x_ext < w_spd) ? (w_x_ext + C_SCREEN - w_spd) : (w_x_ext - w_spd);
    assign w_next  = i_dir ? XW'(w_left) : XW'(w_right);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= C_INIT;
        end else if (i_load) begin
            r_x <= C_INIT;
        end else if (i_en) begin
            r_x <= w_next;
        end
    end

    assign o_x = r_x;

endmodule : lane_obstacle
`default_nettype wire

// File: rtl/lane_runner_engine.sv
`default_nettype none
// ============================================================================
// Module   : lane_runner_engine
// Brief    : Game-phase FSM, player row, collision, lives and score.
// Revision : 1.0
// ============================================================================
module lane_runner_engine
    import lane_runner_pkg::*;
#(
    parameter int NUM_LANES = C_NUM_LANES,
    parameter int XW        = C_XW,
    parameter int SCREEN_W  = C_SCREEN_W,
    parameter int OBJ_W     = C_OBJ_W,
    parameter int PLAYER_X  = C_PLAYER_X,
    parameter int PLAYER_HW = C_PLAYER_HW,
    parameter int SPEED_W   = C_SPEED_W,
    parameter int LIVES     = C_LIVES,
    parameter int SCORE_MAX = C_SCORE_MAX,
    parameter int HIT_TICKS = C_HIT_TICKS
) (
    input  wire logic          clk,
    input  wire logic          reset,
    lane_runner_engine_if.slave bus
);
    localparam int ROW_W   = $clog2(NUM_LANES + 1);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int SCORE_W = $clog2(SCORE_MAX + 1);
    localparam int CNT_W   = $clog2(HIT_TICKS + 1);

    localparam logic [ROW_W-1:0]   C_START_ROW = ROW_W'(NUM_LANES);
    localparam logic [LIVES_W-1:0] C_LIVES_INI = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0] C_SCORE_TOP = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]   C_HIT_LAST  = CNT_W'(HIT_TICKS - 1);
    localparam logic [XW:0]        C_HIT_RIGHT = (XW+1)'(PLAYER_X + PLAYER_HW);
    localparam logic [XW:0]        C_HIT_LEFT  = (XW+1)'(PLAYER_X - PLAYER_HW);
    localparam logic [XW:0]        C_OBJ       = (XW+1)'(OBJ_W);

    state_t             r_state, w_state_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_hit, w_hit_nxt;
    logic               w_reinit;
    logic               w_obs_en;
    logic               w_up, w_down, w_cross, w_collide;
    logic [SCORE_W-1:0] w_score_inc;
    logic [XW-1:0]      w_lane_x;

    assign w_obs_en = bus.tick && ((r_state == ST_PLAY) || (r_state == ST_HIT));

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_obstacle #(
            .XW       (XW),
            .SPEED_W  (SPEED_W),
            .SCREEN_W (SCREEN_W),
            .INIT_X   (gi * (SCREEN_W / NUM_LANES))
        ) u_obstacle (
            .clk     (clk),
            .rst_n   (reset),
            .i_en    (w_obs_en),
            .i_load  (w_reinit),
            .i_speed (bus.lane_speed[gi*SPEED_W +: SPEED_W]),
            .i_dir   (bus.lane_dir[gi]),
            .o_x     (bus.obs_x[gi*XW +: XW])
        );
    end

    always_comb begin
        w_lane_x = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_row == ROW_W'(i)) begin
                w_lane_x = bus.obs_x[i*XW +: XW];
            end
        end
    end

    // Obstacle span is compared unwrapped; the start row never matches a lane.
    assign w_collide   = (r_state == ST_PLAY) && (r_row < C_START_ROW) &&
                         ({1'b0, w_lane_x} < C_HIT_RIGHT) &&
                         (({1'b0, w_lane_x} + C_OBJ) > C_HIT_LEFT);
    assign w_up        = bus.btn_up && !bus.btn_down;
    assign w_down      = bus.btn_down && !bus.btn_up;
    assign w_cross     = w_up && (r_row == '0);
    assign w_score_inc = r_score + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_cnt_nxt   = r_cnt;
        w_hit_nxt   = 1'b0;
        w_reinit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                // A winning crossing beats a collision in lane 0.
                if (w_cross && (w_score_inc == C_SCORE_TOP)) begin
                    w_score_nxt = w_score_inc;
                    w_row_nxt   = C_START_ROW;
                    w_state_nxt = ST_WIN;
                end else if (w_collide) begin
                    w_hit_nxt   = 1'b1;
                    w_lives_nxt = r_lives - 1'b1;
                    w_row_nxt   = C_START_ROW;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HIT;
                end else if (w_cross) begin
                    w_score_nxt = w_score_inc;
                    w_row_nxt   = C_START_ROW;
                end else if (w_up) begin
                    w_row_nxt = r_row - 1'b1;
                end else if (w_down && (r_row < C_START_ROW)) begin
                    w_row_nxt = r_row + 1'b1;
                end
            end
            ST_HIT: begin
                if (bus.tick) begin
                    if (r_cnt == C_HIT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_lives == '0) ? ST_OVER : ST_PLAY;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_WIN, ST_OVER: begin
                if (bus.start) begin
                    w_reinit    = 1'b1;
                    w_lives_nxt = C_LIVES_INI;
                    w_score_nxt = '0;
                    w_row_nxt   = C_START_ROW;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PLAY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_row   <= C_START_ROW;
            r_lives <= C_LIVES_INI;
            r_score <= '0;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_lives <= w_lives_nxt;
            r_score <= w_score_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign bus.player_row = r_row;
    assign bus.state      = r_state;
    assign bus.lives      = r_lives;
    assign bus.score      = r_score;
    assign bus.hit        = r_hit;

endmodule : lane_runner_engine
`default_nettype wire

// File: tb/tb_lane_runner_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_runner_engine
// Brief    : Scenario-driven self-checking bench for lane_runner_engine.
// Revision : 1.0
// ============================================================================
module tb_lane_runner_engine;
    import lane_runner_pkg::*;

    localparam int NL = 6;
    localparam int XW = 10;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    int   m_x[NL];
    int   m_spd[NL];
    bit   m_dir[NL];
    logic [NL*XW-1:0] q_obs[$];
    int   q_row[$];
    logic [NL*XW-1:0] init_obs;

    lane_runner_engine_if #(.NUM_LANES(NL), .XW(XW), .SPEED_W(SW), .LIVES(3), .SCORE_MAX(10)) bus ();

    lane_runner_engine #(
        .NUM_LANES(NL), .XW(XW), .SCREEN_W(640), .OBJ_W(20), .PLAYER_X(320),
        .PLAYER_HW(30), .SPEED_W(SW), .LIVES(3), .SCORE_MAX(10), .HIT_TICKS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [NL*XW-1:0] pack_model();
        logic [NL*XW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*XW +: XW] = XW'(m_x[i]);
        return r;
    endfunction

    task automatic model_init();
        for (int i = 0; i < NL; i++) m_x[i] = i * (640 / NL);
    endtask

    task automatic model_advance();
        for (int i = 0; i < NL; i++) begin
            if (!m_dir[i]) m_x[i] = (m_x[i] + m_spd[i] >= 640) ? m_x[i] + m_spd[i] - 640 : m_x[i] + m_spd[i];
            else           m_x[i] = (m_x[i] < m_spd[i]) ? m_x[i] + 640 - m_spd[i] : m_x[i] - m_spd[i];
        end
    endtask

    task automatic set_lane(input int i, input int s, input bit d);
        m_spd[i] = s;
        m_dir[i] = d;
        bus.lane_speed[i*SW +: SW] = SW'(s);
        bus.lane_dir[i] = d;
    endtask

    task automatic clear_speeds();
        for (int i = 0; i < NL; i++) set_lane(i, 0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    endtask

    // Tick with obstacles expected to move (moves=1) or stay frozen (moves=0).
    task automatic do_tick(input bit moves);
        logic [NL*XW-1:0] exp_obs;
        bus.tick = 1'b1;
        if (moves) model_advance();
        q_obs.push_back(pack_model());
        step();
        exp_obs = q_obs.pop_front();
        checks++;
        if (bus.obs_x !== exp_obs) begin
            errors++;
            $display("FAIL obs_x_tick got %h want %h", bus.obs_x, exp_obs);
        end
    endtask

    task automatic press(input bit up, input bit dn, input int exp_row);
        int want;
        bus.btn_up = up; bus.btn_down = dn;
        q_row.push_back(exp_row);
        step();
        want = q_row.pop_front();
        checks++;
        if (int'(bus.player_row) !== want) begin
            errors++;
            $display("FAIL player_row got %0d want %0d", bus.player_row, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tick = 1'b0; bus.start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        bus.lane_speed = '0; bus.lane_dir = '0;
        clear_speeds();
        model_init();
        init_obs = {10'd530, 10'd424, 10'd318, 10'd212, 10'd106, 10'd0};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.obs_x !== init_obs) begin errors++; $display("FAIL reset_obs got %h want %h", bus.obs_x, init_obs); end
        checks++; if (bus.player_row !== 3'd6) begin errors++; $display("FAIL reset_row got %0d want 6", bus.player_row); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", bus.lives); end
        checks++; if (bus.score !== 4'd0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.score); end
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0d want 0", bus.hit); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_start();
        do_tick(1'b0);
        bus.start = 1'b1;
        step();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", bus.state); end
        checks++; if (bus.obs_x !== init_obs) begin errors++; $display("FAIL start_obs got %h want %h", bus.obs_x, init_obs); end
    endtask

    task automatic test_wrap();
        set_lane(0, 10, 1'b1); set_lane(1, 15, 1'b1);
        do_tick(1'b1);
        set_lane(0, 0, 1'b0);
        repeat (5) do_tick(1'b1);
        set_lane(1, 13, 1'b1);
        do_tick(1'b1);
        checks++; if (bus.obs_x[0 +: XW] !== 10'd630 || bus.obs_x[XW +: XW] !== 10'd3) begin
            errors++; $display("FAIL wrap_setup got %0d,%0d want 630,3", bus.obs_x[0 +: XW], bus.obs_x[XW +: XW]);
        end
        set_lane(0, 10, 1'b0); set_lane(1, 7, 1'b1);
        do_tick(1'b1);
        checks++; if (bus.obs_x[0 +: XW] !== 10'd0) begin errors++; $display("FAIL wrap_right got %0d want 0", bus.obs_x[0 +: XW]); end
        checks++; if (bus.obs_x[XW +: XW] !== 10'd636) begin errors++; $display("FAIL wrap_left got %0d want 636", bus.obs_x[XW +: XW]); end
        clear_speeds();
    endtask

    task automatic clear_lane3();
        set_lane(3, 15, 1'b1);
        repeat (4) do_tick(1'b1);
        clear_speeds();
        checks++; if (bus.obs_x[3*XW +: XW] !== 10'd258) begin errors++; $display("FAIL lane3_clear got %0d want 258", bus.obs_x[3*XW +: XW]); end
    endtask

    task automatic test_climb();
        for (int r = 5; r >= 0; r--) press(1'b1, 1'b0, r);
        press(1'b1, 1'b0, 6);
        checks++; if (bus.score !== 4'd1) begin errors++; $display("FAIL climb_score got %0d want 1", bus.score); end
    endtask

    task automatic test_both_buttons();
        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b1, 5);
        press(1'b0, 1'b1, 6);
        press(1'b0, 1'b1, 6);
        checks++; if (bus.state !== 3'd1 || bus.lives !== 2'd3) begin
            errors++; $display("FAIL buttons_status got state %0d lives %0d want 1,3", bus.state, bus.lives);
        end
    endtask

    task automatic place_lane5_at_300();
        set_lane(5, 15, 1'b1);
        repeat (15) do_tick(1'b1);
        set_lane(5, 5, 1'b1);
        do_tick(1'b1);
        clear_speeds();
        checks++; if (bus.obs_x[5*XW +: XW] !== 10'd300) begin errors++; $display("FAIL lane5_place got %0d want 300", bus.obs_x[5*XW +: XW]); end
    endtask

    task automatic take_hit(input int exp_lives, input int exp_after);
        press(1'b1, 1'b0, 5);
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_early got %0d want 0", bus.hit); end
        step();
        checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit_pulse got %0d want 1", bus.hit); end
        checks++; if (int'(bus.lives) !== exp_lives) begin errors++; $display("FAIL hit_lives got %0d want %0d", bus.lives, exp_lives); end
        checks++; if (bus.player_row !== 3'd6 || bus.state !== 3'd2) begin
            errors++; $display("FAIL hit_enter got row %0d state %0d want 6,2", bus.player_row, bus.state);
        end
        press(1'b1, 1'b0, 6);
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_single got %0d want 0", bus.hit); end
        for (int k = 0; k < 8; k++) begin
            do_tick(1'b1);
            checks++;
            if (int'(bus.state) !== ((k == 7) ? exp_after : 2)) begin
                errors++; $display("FAIL hit_count tick %0d got %0d want %0d", k, bus.state, (k == 7) ? exp_after : 2);
            end
        end
    endtask

    task automatic test_collision();
        place_lane5_at_300();
        set_lane(0, 1, 1'b0);
        take_hit(2, 1);
        clear_speeds();
    endtask

    task automatic test_game_over();
        take_hit(1, 1);
        take_hit(0, 4);
        set_lane(0, 5, 1'b0);
        do_tick(1'b0);
        clear_speeds();
        bus.start = 1'b1;
        model_init();
        step();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL restart_state got %0d want 1", bus.state); end
        checks++; if (bus.lives !== 2'd3 || bus.score !== 4'd0) begin
            errors++; $display("FAIL restart_counts got lives %0d score %0d want 3,0", bus.lives, bus.score);
        end
        checks++; if (bus.obs_x !== init_obs) begin errors++; $display("FAIL restart_obs got %h want %h", bus.obs_x, init_obs); end
    endtask

    task automatic test_reset_mid_hit();
        place_lane5_at_300();
        press(1'b1, 1'b0, 5);
        step();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL midhit_enter got %0d want 2", bus.state); end
        #1 reset = 1'b0;
        #1;
        model_init();
        checks++; if (bus.state !== 3'd0 || bus.lives !== 2'd3 || bus.score !== 4'd0) begin
            errors++; $display("FAIL async_reset got state %0d lives %0d score %0d want 0,3,0", bus.state, bus.lives, bus.score);
        end
        checks++; if (bus.obs_x !== init_obs || bus.player_row !== 3'd6) begin
            errors++; $display("FAIL async_reset_pos got %h row %0d want %h row 6", bus.obs_x, bus.player_row, init_obs);
        end
        #1 reset = 1'b1;
        step();
    endtask

    task automatic test_win();
        bus.start = 1'b1;
        step();
        clear_lane3();
        for (int c = 1; c <= 10; c++) begin
            for (int r = 5; r >= 0; r--) press(1'b1, 1'b0, r);
            press(1'b1, 1'b0, 6);
            checks++; if (int'(bus.score) !== c) begin errors++; $display("FAIL win_score got %0d want %0d", bus.score, c); end
            checks++; if (int'(bus.state) !== ((c == 10) ? 3 : 1)) begin
                errors++; $display("FAIL win_state got %0d want %0d", bus.state, (c == 10) ? 3 : 1);
            end
        end
        press(1'b1, 1'b0, 6);
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap();
        clear_lane3();
        test_climb();
        test_both_buttons();
        test_collision();
        test_game_over();
        test_reset_mid_hit();
        test_win();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lane_runner_engine
`default_nettype wire
